// File: rtl/frame_fetch_scheduler_pkg.sv
// Shared fetch-path types and defaults used by the scheduler, the scan driver and the line buffer.
package frame_fetch_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  localparam int unsigned FFS_ADDRESS_WIDTH   = 25;
  localparam int unsigned FFS_ROWS            = 32;
  localparam int unsigned FFS_LINE_BYTES      = 192;
  localparam int unsigned FFS_BANK_A_BASE     = 0;
  localparam int unsigned FFS_BANK_B_BASE     = 8192;
  localparam int unsigned FFS_MAX_OUTSTANDING = 8;

  function automatic int unsigned bank_base(input logic bank,
                                            input int unsigned base_a,
                                            input int unsigned base_b);
    return bank ? base_b : base_a;
  endfunction

endpackage

// File: rtl/frame_fetch_scheduler_credit.sv
// Outstanding-read tracker: up/down counter, +1 per issue, -1 per return; no added latency.
// can_issue drops combinationally once MAX_OUTSTANDING reads are in flight.
module fetch_credit_counter
  import frame_fetch_scheduler_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = FFS_MAX_OUTSTANDING
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   i_issue,
  input  logic                                   i_return,
  output logic                                   o_can_issue,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] r_cnt;
  logic          w_inc;
  logic          w_dec;

  // Saturating guards keep the count inside [0, MAX_OUTSTANDING] whatever the inputs do.
  assign w_inc = i_issue && (r_cnt < CW'(MAX_OUTSTANDING));
  assign w_dec = i_return && (r_cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dec && !w_inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_can_issue   = (r_cnt < CW'(MAX_OUTSTANDING));
  assign o_outstanding = r_cnt;

endmodule

// File: rtl/frame_fetch_scheduler.sv
// Fetches one display row per line request from frame RAM into the line buffer; lb writes lag returns by 1 cycle.
// Issue stalls on arbiter FIFO full or MAX_OUTSTANDING in flight; bank swaps apply only at a row-0 request.
module frame_fetch_scheduler
  import frame_fetch_scheduler_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = FFS_ADDRESS_WIDTH,
  parameter int unsigned ROWS            = FFS_ROWS,
  parameter int unsigned LINE_BYTES      = FFS_LINE_BYTES,
  parameter int unsigned BANK_A_BASE     = FFS_BANK_A_BASE,
  parameter int unsigned BANK_B_BASE     = FFS_BANK_B_BASE,
  parameter int unsigned MAX_OUTSTANDING = FFS_MAX_OUTSTANDING
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_line_req,
  input  logic [$clog2(ROWS)-1:0]       i_line_row,
  output logic                          o_line_busy,
  output logic                          o_line_done,
  output logic                          o_overrun,
  input  logic                          i_swap_req,
  output logic                          o_swap_ack,
  output logic                          o_active_bank,
  output logic [ADDRESS_WIDTH-1:0]      o_mem_address,
  output logic                          o_mem_wr,
  output logic [7:0]                    o_mem_data,
  output logic                          o_mem_data_ready,
  input  logic                          i_mem_fifo_full,
  input  logic [7:0]                    i_mem_q,
  input  logic                          i_mem_q_ready,
  output logic                          o_lb_wr_en,
  output logic [$clog2(LINE_BYTES)-1:0] o_lb_wr_addr,
  output logic [7:0]                    o_lb_wr_data
);

  localparam int unsigned CNT_W = $clog2(LINE_BYTES + 1);
  localparam int unsigned LB_AW = $clog2(LINE_BYTES);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned ROW_W = $clog2(ROWS);

  fetch_state_t             r_state;
  logic [CNT_W-1:0]         r_issue_cnt;
  logic [CNT_W-1:0]         r_ret_cnt;
  logic [ADDRESS_WIDTH-1:0] r_line_addr;
  logic                     r_active_bank;
  logic                     r_swap_pending;
  logic                     r_swap_ack;
  logic                     r_line_busy;
  logic                     r_line_done;
  logic                     r_overrun;
  logic                     r_lb_wr_en;
  logic [LB_AW-1:0]         r_lb_wr_addr;
  logic [7:0]               r_lb_wr_data;

  logic                     w_can_issue;
  logic [OUT_W-1:0]         w_outstanding;
  logic                     w_accept;
  logic                     w_swap_apply;
  logic                     w_bank_next;
  logic [ROW_W-1:0]         w_row;
  logic [ADDRESS_WIDTH-1:0] w_line_addr_next;
  logic                     w_issue;
  logic                     w_return;

  assign w_accept = (r_state == ST_IDLE) && i_line_req;
  assign w_row    = (32'(i_line_row) >= ROWS) ? '0 : i_line_row;

  // Swapping only at the first row of a frame keeps a frame from mixing banks.
  assign w_swap_apply     = w_accept && r_swap_pending && (w_row == '0);
  assign w_bank_next      = r_active_bank ^ w_swap_apply;
  assign w_line_addr_next = ADDRESS_WIDTH'(bank_base(w_bank_next, BANK_A_BASE, BANK_B_BASE))
                          + ADDRESS_WIDTH'(w_row) * ADDRESS_WIDTH'(LINE_BYTES);

  assign w_issue  = (r_state == ST_ISSUE) && !i_mem_fifo_full && w_can_issue
                 && (r_issue_cnt < CNT_W'(LINE_BYTES));
  assign w_return = ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) && i_mem_q_ready
                 && (w_outstanding != '0);

  fetch_credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_issue       (w_issue),
    .i_return      (w_return),
    .o_can_issue   (w_can_issue),
    .o_outstanding (w_outstanding)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_issue_cnt    <= '0;
      r_ret_cnt      <= '0;
      r_line_addr    <= '0;
      r_active_bank  <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_ack     <= 1'b0;
      r_line_busy    <= 1'b0;
      r_line_done    <= 1'b0;
      r_overrun      <= 1'b0;
      r_lb_wr_en     <= 1'b0;
      r_lb_wr_addr   <= '0;
      r_lb_wr_data   <= '0;
    end else begin
      r_line_done <= 1'b0;
      r_swap_ack  <= 1'b0;
      r_lb_wr_en  <= 1'b0;

      if (w_swap_apply) begin
        r_swap_pending <= 1'b0;
      end else if (i_swap_req) begin
        r_swap_pending <= 1'b1;
      end

      if (i_line_req && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end

      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end

      // Returns arrive in issue order, so the return count is the line buffer index.
      if (w_return) begin
        r_ret_cnt    <= r_ret_cnt + 1'b1;
        r_lb_wr_en   <= 1'b1;
        r_lb_wr_addr <= r_ret_cnt[LB_AW-1:0];
        r_lb_wr_data <= i_mem_q;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_line_req) begin
            r_state       <= ST_ISSUE;
            r_line_addr   <= w_line_addr_next;
            r_active_bank <= w_bank_next;
            r_swap_ack    <= w_swap_apply;
            r_issue_cnt   <= '0;
            r_ret_cnt     <= '0;
            r_line_busy   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_issue_cnt == CNT_W'(LINE_BYTES)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_ret_cnt == CNT_W'(LINE_BYTES)) begin
            r_state     <= ST_DONE;
            r_line_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_line_busy <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_data_ready = w_issue;
  assign o_mem_address    = w_issue ? (r_line_addr + ADDRESS_WIDTH'(r_issue_cnt)) : '0;
  assign o_mem_wr         = 1'b0;
  assign o_mem_data       = 8'h00;
  assign o_line_busy      = r_line_busy;
  assign o_line_done      = r_line_done;
  assign o_overrun        = r_overrun;
  assign o_swap_ack       = r_swap_ack;
  assign o_active_bank    = r_active_bank;
  assign o_lb_wr_en       = r_lb_wr_en;
  assign o_lb_wr_addr     = r_lb_wr_addr;
  assign o_lb_wr_data     = r_lb_wr_data;

endmodule

// File: tb/tb_frame_fetch_scheduler.sv
// Bench for frame_fetch_scheduler: table of line fetches driven against an in-order arbiter model,
// with a scoreboard of expected line-buffer writes, plus stray-return and mid-drain reset sequences.
module tb_frame_fetch_scheduler;
  import frame_fetch_scheduler_pkg::*;

  localparam int AW   = 25;
  localparam int LB   = 192;
  localparam int MAXO = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          line_req = 1'b0;
  logic [4:0]    line_row = '0;
  logic          line_busy, line_done, overrun;
  logic          swap_req = 1'b0;
  logic          swap_ack, active_bank;
  logic [AW-1:0] mem_address;
  logic          mem_wr;
  logic [7:0]    mem_data;
  logic          mem_data_ready;
  logic          mem_fifo_full = 1'b0;
  logic [7:0]    mem_q = 8'h00;
  logic          mem_q_ready = 1'b0;
  logic          lb_wr_en;
  logic [7:0]    lb_wr_addr;
  logic [7:0]    lb_wr_data;

  always #5 clk = ~clk;

  frame_fetch_scheduler dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_line_req       (line_req),
    .i_line_row       (line_row),
    .o_line_busy      (line_busy),
    .o_line_done      (line_done),
    .o_overrun        (overrun),
    .i_swap_req       (swap_req),
    .o_swap_ack       (swap_ack),
    .o_active_bank    (active_bank),
    .o_mem_address    (mem_address),
    .o_mem_wr         (mem_wr),
    .o_mem_data       (mem_data),
    .o_mem_data_ready (mem_data_ready),
    .i_mem_fifo_full  (mem_fifo_full),
    .i_mem_q          (mem_q),
    .i_mem_q_ready    (mem_q_ready),
    .o_lb_wr_en       (lb_wr_en),
    .o_lb_wr_addr     (lb_wr_addr),
    .o_lb_wr_data     (lb_wr_data)
  );

  typedef struct {
    int   addr;
    logic [7:0] dat;
  } lbw_t;

  typedef struct {
    int row;
    bit swap_mid;
    bit ret_stall;
    bit full_stall;
    bit req_mid;
    int exp_base;
    bit exp_bank;
    bit exp_ack;
    bit exp_overrun;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] arb_q[$];
  lbw_t          exp_q[$];
  lbw_t          e;
  logic [AW-1:0] ra;
  int            n_iss = 0;
  int            ret_idx = 0;
  int            n_lb = 0;
  int            n_ack = 0;
  int            exp_base = 0;
  bit            ret_en = 1'b1;
  bit            full_ctl = 1'b0;
  bit            stray = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Arbiter model: in-order returns one cycle or more after acceptance; records every issue.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      arb_q.delete();
      exp_q.delete();
      mem_q_ready = 1'b0;
      mem_q       = 8'h00;
    end else begin
      mem_fifo_full = full_ctl;
      if (stray) begin
        mem_q_ready = 1'b1;
        mem_q       = 8'hA5;
      end else if (ret_en && arb_q.size() > 0) begin
        ra          = arb_q.pop_front();
        mem_q_ready = 1'b1;
        mem_q       = mem_byte(ra);
        exp_q.push_back('{addr: ret_idx, dat: mem_q});
        ret_idx++;
      end else begin
        mem_q_ready = 1'b0;
        mem_q       = 8'h00;
      end
    end
    #1;
    if (mem_fifo_full) chk("ready_while_full", 32'(mem_data_ready), 0);
    if (mem_data_ready) begin
      chk("issue_addr", 32'(mem_address), exp_base + n_iss);
      arb_q.push_back(mem_address);
      n_iss++;
    end
    if (lb_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lb_unexpected: write addr %0d with no return pending", lb_wr_addr);
      end else begin
        e = exp_q.pop_front();
        chk("lb_addr", 32'(lb_wr_addr), e.addr);
        chk("lb_data", 32'(lb_wr_data), 32'(e.dat));
      end
      n_lb++;
    end
    if (swap_ack) n_ack++;
  end

  task automatic wait_iss(input int n);
    for (int c = 0; c < 3000 && n_iss < n; c++) @(posedge clk);
    #1;
    chk("wait_issue_reached", 32'(n_iss >= n), 1);
  endtask

  task automatic run_line(input vec_t v);
    bit got;
    int snap;
    n_iss    = 0;
    ret_idx  = 0;
    n_lb     = 0;
    exp_base = v.exp_base;
    if (v.ret_stall) ret_en = 1'b0;
    @(posedge clk); #1;
    line_req = 1'b1;
    line_row = 5'(v.row);
    @(posedge clk); #1;
    line_req = 1'b0;
    chk("busy_after_req", 32'(line_busy), 1);
    chk("swap_ack", 32'(swap_ack), 32'(v.exp_ack));
    chk("active_bank", 32'(active_bank), 32'(v.exp_bank));
    if (v.ret_stall) begin
      repeat (20) @(posedge clk);
      #1;
      chk("issued_during_stall", n_iss, MAXO);
      ret_en = 1'b1;
    end
    if (v.full_stall) begin
      wait_iss(50);
      snap     = n_iss;
      full_ctl = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("no_issue_while_full", n_iss, snap);
      full_ctl = 1'b0;
    end
    if (v.swap_mid) begin
      wait_iss(20);
      swap_req = 1'b1;
      @(posedge clk); #1;
      swap_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      swap_req = 1'b1;
      @(posedge clk); #1;
      swap_req = 1'b0;
      chk("bank_held_mid_line", 32'(active_bank), 32'(v.exp_bank));
    end
    if (v.req_mid) begin
      wait_iss(30);
      line_req = 1'b1;
      line_row = 5'd9;
      @(posedge clk); #1;
      line_req = 1'b0;
      chk("overrun_set", 32'(overrun), 1);
    end
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk); #1;
      if (line_done) got = 1'b1;
    end
    chk("line_done_seen", 32'(got), 1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(line_done), 0);
    chk("busy_cleared", 32'(line_busy), 0);
    chk("issue_count", n_iss, LB);
    chk("lb_write_count", n_lb, LB);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("overrun", 32'(overrun), 32'(v.exp_overrun));
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    //          row swp rst fst req base        bank ack ovr
    vecs[0] = '{2,  0,  0,  0,  0,  384,        0,   0,  0};
    vecs[1] = '{7,  0,  1,  0,  0,  1344,       0,   0,  0};
    vecs[2] = '{3,  0,  0,  1,  0,  576,        0,   0,  0};
    vecs[3] = '{5,  1,  0,  0,  0,  960,        0,   0,  0};
    vecs[4] = '{6,  0,  0,  0,  0,  1152,       0,   0,  0};
    vecs[5] = '{0,  0,  0,  0,  0,  8192,       1,   1,  0};
    vecs[6] = '{1,  0,  0,  0,  0,  8384,       1,   0,  0};
    vecs[7] = '{4,  0,  0,  0,  1,  8960,       1,   0,  1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(line_busy), 0);
    chk("rst_done", 32'(line_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_swap_ack", 32'(swap_ack), 0);
    chk("rst_bank", 32'(active_bank), 0);
    chk("rst_mem_ready", 32'(mem_data_ready), 0);
    chk("rst_mem_addr", 32'(mem_address), 0);
    chk("rst_lb_wr_en", 32'(lb_wr_en), 0);
    chk("mem_wr_tied", 32'(mem_wr), 0);
    chk("mem_data_tied", 32'(mem_data), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_line(vecs[i]);
    chk("swap_ack_pulses", n_ack, 1);

    // Stray return while idle must not reach the line buffer.
    @(posedge clk); #1;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    chk("stray_no_write", 32'(lb_wr_en), 0);
    chk("stray_idle", 32'(line_busy), 0);

    // Reset while draining: row 10 of bank 1, hold back the final return.
    n_iss    = 0;
    ret_idx  = 0;
    n_lb     = 0;
    exp_base = 8192 + 10 * LB;
    @(posedge clk); #1;
    line_req = 1'b1;
    line_row = 5'd10;
    @(posedge clk); #1;
    line_req = 1'b0;
    wait_iss(LB);
    ret_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_busy", 32'(line_busy), 1);
    chk("drain_no_issue", 32'(mem_data_ready), 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(line_busy), 0);
    chk("mid_rst_done", 32'(line_done), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_bank", 32'(active_bank), 0);
    chk("mid_rst_swap_ack", 32'(swap_ack), 0);
    chk("mid_rst_mem_ready", 32'(mem_data_ready), 0);
    chk("mid_rst_mem_addr", 32'(mem_address), 0);
    chk("mid_rst_lb_wr_en", 32'(lb_wr_en), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ret_en  = 1'b1;
    v = '{1, 0, 0, 0, 0, 192, 0, 0, 0};
    run_line(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
